neuron_mac_sekvencer: RTL and testbench
=======================================

Name: neuron_mac_sekvencer

Overview:
Serial controller for one hidden-layer neuron. It time-multiplexes a single shared `mnozenje` multiplier across all BROJ_ULAZA weight×sample products and reads weights from an external synchronous ROM. It accumulates the products into separate positive and negative sums, forms the sign-magnitude difference for `Sigmoid_LUT`, and registers the resulting probability. It replaces the fully parallel 60-multiplier neuron where area matters.

Parameters:
BROJ_ULAZA, 60, number of inputs/weights per neuron
SIRINA, 16, width of one sample, weight and product
SIRINA_SUME, 22, accumulator width; 60×(2^16−1) fits without overflow
SIRINA_ADR, 6, weight ROM address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to evaluate the neuron; sampled only in IDLE
uzorak  in  BROJ_ULAZA*SIRINA  input vector; slice k = uzorak[16k+15:16k]
tezina_adr  out  SIRINA_ADR  weight ROM address
tezina  in  SIRINA  ROM data, valid one cycle after tezina_adr; bit15 = sign (1 = negative)
mul_weight  out  SIRINA  operand to the shared mnozenje
mul_sample  out  SIRINA  operand to the shared mnozenje
mul_product  in  SIRINA  combinational product magnitude from mnozenje
suma  out  SIRINA_SUME  registered |P−N|, drives Sigmoid_LUT.suma
predznak  out  1  registered sign, drives Sigmoid_LUT.predznak
vjerojatnost  in  SIRINA  Sigmoid_LUT output
izlaz  out  SIRINA  registered neuron output
zauzet  out  1  high while an evaluation is in progress
gotovo  out  1  one-cycle pulse when izlaz is updated

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All registers clear: P_suma, N_suma, counter k, suma, predznak, izlaz, the sample latch, tezina_adr, zauzet and gotovo are all 0.
- States: IDLE → FETCH → MAC → SUB → LUT → IDLE.
- IDLE:
  - zauzet=0.
  - On start=1, at edge E0: latch uzorak internally, clear P_suma/N_suma, set k=0, tezina_adr=0, go to FETCH.
- FETCH (one cycle):
  - At edge E1: tezina_adr becomes 1 and the state goes to MAC.
  - tezina now holds word 0.
- MAC (BROJ_ULAZA cycles, k = 0..59):
  - mul_weight=tezina; mul_sample=latched slice k.
  - At each edge: if tezina[15]=0 then P_suma += mul_product, else N_suma += mul_product (zero-extended).
  - k increments; tezina_adr = min(k+2, BROJ_ULAZA−1), clamped at 59.
  - After the edge that accumulates k=59 (E61), go to SUB.
- SUB:
  - At E62: if P_suma > N_suma then suma=P−N, predznak=0; else suma=N−P, predznak=1.
  - A tie gives suma=0, predznak=1.
  - Go to LUT.
- LUT:
  - At E63: izlaz=vjerojatnost, gotovo=1 for exactly one cycle, go to IDLE.
- Latency: gotovo is high in the cycle after E63, which is BROJ_ULAZA+3 edges after start is sampled.
- zauzet is 1 from after E0 through after E62, and 0 while gotovo is high.
- Outside MAC, mul_weight and mul_sample are 0.
- start while zauzet=1 is ignored. start in the gotovo cycle is accepted, since the state is already IDLE.
- izlaz, suma and predznak hold their values until the next evaluation updates them.
- Changes on uzorak after E0 do not affect the running evaluation.
- Reset asserted mid-evaluation aborts it immediately: no gotovo pulse, izlaz=0.

Test Plan:
1. Reset mid-MAC (at k=30) → zauzet=0 and izlaz=0 at once. gotovo never pulses. A new start then completes normally after 63 edges.
2. ROM model holds the 26-positive/34-negative pattern; stub mul_product=16'h0010 → P=416, N=544, suma=128, predznak=1. izlaz equals the LUT stub value for (128,1); gotovo pulses exactly 63 edges after start.
3. All weights positive; mul_product=16'hFFFF → P=3932100, N=0, suma=3932100, predznak=0, with no overflow.
4. mul_product=0 → suma=0, predznak=1 (tie rule).
5. start is re-pulsed during MAC and uzorak is changed after E0 → only one gotovo; the result equals the value computed from the original uzorak. tezina_adr sequence is 0,1,…,59,59.
6. start asserted in the gotovo cycle → the second evaluation starts immediately; back-to-back gotovo pulses are 64 cycles apart.

Source files
------------

// File: rtl/neuron_mac_sekvencer.sv
// Serial hidden-layer neuron: one shared multiplier, weights streamed from a
// synchronous ROM, split positive/negative accumulation, sigmoid via external LUT.
module neuron_mac_sekvencer #(
    parameter int BROJ_ULAZA  = 60,
    parameter int SIRINA      = 16,
    parameter int SIRINA_SUME = 22,
    parameter int SIRINA_ADR  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BROJ_ULAZA*SIRINA-1:0]  uzorak,
    output logic [SIRINA_ADR-1:0]         tezina_adr,
    input  logic [SIRINA-1:0]             tezina,
    output logic [SIRINA-1:0]             mul_weight,
    output logic [SIRINA-1:0]             mul_sample,
    input  logic [SIRINA-1:0]             mul_product,
    output logic [SIRINA_SUME-1:0]        suma,
    output logic                          predznak,
    input  logic [SIRINA-1:0]             vjerojatnost,
    output logic [SIRINA-1:0]             izlaz,
    output logic                          zauzet,
    output logic                          gotovo
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        SUB,
        LUT
    } stanje_t;

    localparam logic [SIRINA_ADR-1:0] ZADNJI = SIRINA_ADR'(BROJ_ULAZA - 1);

    stanje_t                  stanje;
    logic [SIRINA_SUME-1:0]   p_suma;
    logic [SIRINA_SUME-1:0]   n_suma;
    logic [SIRINA_ADR-1:0]    k;
    logic [SIRINA-1:0]        uzorak_mem [BROJ_ULAZA];
    logic [SIRINA_ADR:0]      adr_plus_dva;
    logic [SIRINA_ADR-1:0]    adr_sljedeca;
    logic [SIRINA_SUME-1:0]   produkt_ext;

    // ROM runs two words ahead of k because its data arrives one cycle late.
    always_comb begin
        adr_plus_dva = {1'b0, k} + (SIRINA_ADR + 1)'(2);
        adr_sljedeca = ZADNJI;
        if (adr_plus_dva < {1'b0, ZADNJI}) begin
            adr_sljedeca = adr_plus_dva[SIRINA_ADR-1:0];
        end
    end

    assign produkt_ext = {{(SIRINA_SUME - SIRINA){1'b0}}, mul_product};

    always_comb begin
        mul_weight = '0;
        mul_sample = '0;
        if (stanje == MAC) begin
            mul_weight = tezina;
            mul_sample = uzorak_mem[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje     <= IDLE;
            p_suma     <= '0;
            n_suma     <= '0;
            k          <= '0;
            suma       <= '0;
            predznak   <= 1'b0;
            izlaz      <= '0;
            tezina_adr <= '0;
            zauzet     <= 1'b0;
            gotovo     <= 1'b0;
            for (int i = 0; i < BROJ_ULAZA; i++) begin
                uzorak_mem[i] <= '0;
            end
        end else begin
            gotovo <= 1'b0;
            case (stanje)
                IDLE: begin
                    zauzet <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < BROJ_ULAZA; i++) begin
                            uzorak_mem[i] <= uzorak[i*SIRINA +: SIRINA];
                        end
                        p_suma     <= '0;
                        n_suma     <= '0;
                        k          <= '0;
                        tezina_adr <= '0;
                        zauzet     <= 1'b1;
                        stanje     <= FETCH;
                    end
                end
                FETCH: begin
                    tezina_adr <= SIRINA_ADR'(1);
                    stanje     <= MAC;
                end
                MAC: begin
                    if (tezina[SIRINA-1]) begin
                        n_suma <= n_suma + produkt_ext;
                    end else begin
                        p_suma <= p_suma + produkt_ext;
                    end
                    tezina_adr <= adr_sljedeca;
                    k          <= k + SIRINA_ADR'(1);
                    if (k == ZADNJI) begin
                        stanje <= SUB;
                    end
                end
                SUB: begin
                    // A tie is reported as negative zero.
                    if (p_suma > n_suma) begin
                        suma     <= p_suma - n_suma;
                        predznak <= 1'b0;
                    end else begin
                        suma     <= n_suma - p_suma;
                        predznak <= 1'b1;
                    end
                    stanje <= LUT;
                end
                LUT: begin
                    izlaz  <= vjerojatnost;
                    gotovo <= 1'b1;
                    zauzet <= 1'b0;
                    stanje <= IDLE;
                end
                default: begin
                    stanje <= IDLE;
                    zauzet <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_sekvencer.sv
// Directed bench for neuron_mac_sekvencer with ROM, multiplier and sigmoid stubs.
module tb_neuron_mac_sekvencer;

    localparam int BROJ_ULAZA  = 60;
    localparam int SIRINA      = 16;
    localparam int SIRINA_SUME = 22;
    localparam int SIRINA_ADR  = 6;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic [BROJ_ULAZA*SIRINA-1:0]  uzorak;
    logic [SIRINA_ADR-1:0]         tezina_adr;
    logic [SIRINA-1:0]             tezina;
    logic [SIRINA-1:0]             mul_weight;
    logic [SIRINA-1:0]             mul_sample;
    logic [SIRINA-1:0]             mul_product;
    logic [SIRINA_SUME-1:0]        suma;
    logic                          predznak;
    logic [SIRINA-1:0]             vjerojatnost;
    logic [SIRINA-1:0]             izlaz;
    logic                          zauzet;
    logic                          gotovo;

    int checks = 0;
    int errors = 0;

    logic [SIRINA-1:0] rom [BROJ_ULAZA];
    int                prod_mode;
    logic [SIRINA-1:0] prod_const;

    neuron_mac_sekvencer #(
        .BROJ_ULAZA (BROJ_ULAZA),
        .SIRINA     (SIRINA),
        .SIRINA_SUME(SIRINA_SUME),
        .SIRINA_ADR (SIRINA_ADR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .uzorak      (uzorak),
        .tezina_adr  (tezina_adr),
        .tezina      (tezina),
        .mul_weight  (mul_weight),
        .mul_sample  (mul_sample),
        .mul_product (mul_product),
        .suma        (suma),
        .predznak    (predznak),
        .vjerojatnost(vjerojatnost),
        .izlaz       (izlaz),
        .zauzet      (zauzet),
        .gotovo      (gotovo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tezina <= rom[tezina_adr];

    // Multiplier stub: a fixed product, or the sample passed through so the result depends on uzorak.
    always_comb begin
        mul_product = prod_const;
        if (prod_mode == 1) mul_product = mul_sample;
    end

    assign vjerojatnost = {predznak, suma[14:0]} ^ 16'h5A5A;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input int n_pos);
        for (int i = 0; i < BROJ_ULAZA; i++) begin
            rom[i] = ((i < n_pos) ? 16'h0000 : 16'h8000) | 16'(i);
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < BROJ_ULAZA; i++) begin
            uzorak[i*SIRINA +: SIRINA] = 16'(i + 1);
        end
    endtask

    task automatic applyStimulus(output int edges);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!gotovo && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int bad;
        int gcount;
        int exp_adr;

        rst = 1'b1;
        start = 1'b0;
        prod_mode = 0;
        prod_const = '0;
        set_ramp();
        load_rom(26);

        #12;
        $display("[TB] reset values");
        checkOutput("rst_zauzet", 32'(zauzet), 0);
        checkOutput("rst_gotovo", 32'(gotovo), 0);
        checkOutput("rst_izlaz", 32'(izlaz), 0);
        checkOutput("rst_suma", 32'(suma), 0);
        checkOutput("rst_predznak", 32'(predznak), 0);
        checkOutput("rst_adr", 32'(tezina_adr), 0);
        checkOutput("rst_mul_weight", 32'(mul_weight), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] 26 positive / 34 negative weights, constant product 0x10");
        prod_const = 16'h0010;
        applyStimulus(edges);
        checkOutput("t2_latency", 32'(edges), 63);
        checkOutput("t2_suma", 32'(suma), 128);
        checkOutput("t2_predznak", 32'(predznak), 1);
        checkOutput("t2_izlaz", 32'(izlaz), 32'hDADA);
        checkOutput("t2_zauzet_at_gotovo", 32'(zauzet), 0);
        @(posedge clk); #1;
        checkOutput("t2_gotovo_single", 32'(gotovo), 0);
        checkOutput("t2_izlaz_hold", 32'(izlaz), 32'hDADA);
        checkOutput("idle_mul_sample", 32'(mul_sample), 0);

        $display("[TB] reset in the middle of MAC");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        checkOutput("t1_busy_before", 32'(zauzet), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_zauzet", 32'(zauzet), 0);
        checkOutput("t1_izlaz", 32'(izlaz), 0);
        checkOutput("t1_gotovo", 32'(gotovo), 0);
        checkOutput("t1_mul_sample", 32'(mul_sample), 0);
        @(negedge clk) rst = 1'b0;
        gcount = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (gotovo) gcount++;
        end
        checkOutput("t1_no_gotovo", 32'(gcount), 0);
        applyStimulus(edges);
        checkOutput("t1_restart_latency", 32'(edges), 63);
        checkOutput("t1_restart_izlaz", 32'(izlaz), 32'hDADA);

        $display("[TB] all weights positive, product 0xFFFF");
        load_rom(60);
        prod_const = 16'hFFFF;
        applyStimulus(edges);
        checkOutput("t3_latency", 32'(edges), 63);
        checkOutput("t3_suma", 32'(suma), 3932100);
        checkOutput("t3_predznak", 32'(predznak), 0);
        checkOutput("t3_izlaz", 32'(izlaz), 32'h259E);

        $display("[TB] zero product tie");
        prod_const = 16'h0000;
        applyStimulus(edges);
        checkOutput("t4_suma", 32'(suma), 0);
        checkOutput("t4_predznak", 32'(predznak), 1);
        checkOutput("t4_izlaz", 32'(izlaz), 32'hDA5A);

        $display("[TB] start re-pulse and uzorak change during evaluation");
        load_rom(26);
        set_ramp();
        prod_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 0;
        gcount = 0;
        if (tezina_adr !== 6'd0) bad++;
        for (int j = 1; j <= 62; j++) begin
            @(posedge clk); #1;
            exp_adr = (j > 59) ? 59 : j;
            if (32'(tezina_adr) !== 32'(exp_adr)) bad++;
            if (gotovo) gcount++;
            if (j == 1) begin
                for (int i = 0; i < BROJ_ULAZA; i++) uzorak[i*SIRINA +: SIRINA] = 16'h0100;
            end
            if (j == 6) begin
                checkOutput("t5_mul_sample_k5", 32'(mul_sample), 6);
                checkOutput("t5_mul_weight_k5", 32'(mul_weight), 5);
            end
            if (j == 40) checkOutput("t5_mul_weight_k39", 32'(mul_weight), 32'h8027);
            if (j == 10) start = 1'b1;
            if (j == 11) start = 1'b0;
        end
        checkOutput("t5_adr_sequence_bad", 32'(bad), 0);
        @(posedge clk); #1;
        checkOutput("t5_gotovo", 32'(gotovo), 1);
        checkOutput("t5_suma", 32'(suma), 1128);
        checkOutput("t5_predznak", 32'(predznak), 1);
        checkOutput("t5_izlaz", 32'(izlaz), 32'hDE32);
        if (gotovo) gcount++;
        repeat (70) begin
            @(posedge clk); #1;
            if (gotovo) gcount++;
        end
        checkOutput("t5_gotovo_count", 32'(gcount), 1);

        $display("[TB] start accepted in the gotovo cycle");
        prod_mode = 0;
        load_rom(60);
        prod_const = 16'h0001;
        applyStimulus(edges);
        checkOutput("t6_first_gotovo", 32'(gotovo), 1);
        checkOutput("t6_first_izlaz", 32'(izlaz), 32'h5A66);
        load_rom(26);
        prod_const = 16'h0010;
        start = 1'b1;
        edges = 0;
        while (edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                start = 1'b0;
                checkOutput("t6_busy_after_start", 32'(zauzet), 1);
                checkOutput("t6_gotovo_dropped", 32'(gotovo), 0);
            end
            if (gotovo) break;
        end
        checkOutput("t6_pulse_spacing", 32'(edges), 64);
        checkOutput("t6_second_izlaz", 32'(izlaz), 32'hDADA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
